// File: rtl/ssp_pkg.sv
// ---------------------------------------------------------------------------
// ssp_pkg
// Shared definitions for the SSP receive front end.
//   SSP_DATA_WIDTH  : default frame length in bits (width of rxdata)
//   SSP_SYNC_STAGES : default flip-flop depth of the input synchronisers
//   rx_state_t      : receive deserializer state encoding
// ---------------------------------------------------------------------------
package ssp_pkg;

    localparam int SSP_DATA_WIDTH  = 8;
    localparam int SSP_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/ssp_sync_edge.sv
// ---------------------------------------------------------------------------
// ssp_sync_edge
// N-stage synchroniser for one asynchronous input, with an optional
// one-clock falling-edge pulse derived from the synchronised value.
//
// Parameters:
//   STAGES  : synchroniser depth (minimum 2)
//   EDGE_EN : 1 = generate the falling-edge pulse, 0 = plain synchroniser
//             (fall is then tied low)
// Ports:
//   clk     : input  1  sampling clock (rising edge)
//   clear_b : input  1  synchronous active-low reset, clears all history
//   d       : input  1  asynchronous input
//   q       : output 1  synchronised input
//   fall    : output 1  one-clk pulse on a 1->0 transition of q
// ---------------------------------------------------------------------------
module ssp_sync_edge
    import ssp_pkg::*;
#(
    parameter int STAGES  = SSP_SYNC_STAGES,
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic clear_b,
    input  logic d,
    output logic q,
    output logic fall
);

    logic [STAGES-1:0] sync_p;

    always_ff @(posedge clk) begin
        if (!clear_b) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[STAGES-2:0], d};
        end
    end

    assign q = sync_p[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic q_prev;

            always_ff @(posedge clk) begin
                if (!clear_b) begin
                    q_prev <= 1'b0;
                end else begin
                    q_prev <= q;
                end
            end

            // History resets to 0, so a line already high after reset
            // cannot produce a false falling edge.
            assign fall = q_prev & ~q;
        end else begin : g_no_edge
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/ssp_rx_deserializer.sv
// ---------------------------------------------------------------------------
// ssp_rx_deserializer
// Receive-side serial front end of the SSP. Synchronises the external
// serial clock, frame sync and data into the pclk domain and assembles
// DATA_WIDTH-bit frames MSB first. Every completed byte is offered to the
// downstream receive FIFO with a one-pclk w_en strobe; a byte completing
// while the FIFO is full is dropped and flags a sticky overrun.
//
// Parameters:
//   DATA_WIDTH  : frame length in bits and width of rxdata
//   SYNC_STAGES : depth of the input synchronisers (minimum 2)
// Ports:
//   pclk         : input  1           system clock, rising edge
//   clear_b      : input  1           synchronous active-low reset
//   rx_en        : input  1           enable; low forces IDLE
//   sspclkin     : input  1           external serial clock (<= pclk/4)
//   sspfssin     : input  1           frame sync, one sspclk period before MSB
//   ssprxd       : input  1           serial data, sampled on sspclkin fall
//   rx_fifo_full : input  1           receive FIFO full
//   rxdata       : output DATA_WIDTH  last completed byte
//   w_en         : output 1           one-pclk FIFO write strobe
//   rx_overrun   : output 1           sticky overrun flag
//   rx_busy      : output 1           frame armed, shifting or completing
// ---------------------------------------------------------------------------
module ssp_rx_deserializer
    import ssp_pkg::*;
#(
    parameter int DATA_WIDTH  = SSP_DATA_WIDTH,
    parameter int SYNC_STAGES = SSP_SYNC_STAGES
) (
    input  logic                  pclk,
    input  logic                  clear_b,
    input  logic                  rx_en,
    input  logic                  sspclkin,
    input  logic                  sspfssin,
    input  logic                  ssprxd,
    input  logic                  rx_fifo_full,
    output logic [DATA_WIDTH-1:0] rxdata,
    output logic                  w_en,
    output logic                  rx_overrun,
    output logic                  rx_busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    // -----------------------------------------------------------------------
    // Input synchronisers (stage boundary: async pins -> pclk domain)
    // -----------------------------------------------------------------------
    logic fall_tick;
    logic fss_s;
    logic rxd_s;
    logic unused_sspclk_s;
    logic unused_fss_fall;
    logic unused_rxd_fall;

    ssp_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .EDGE_EN (1'b1)
    ) u_sync_clk (
        .clk     (pclk),
        .clear_b (clear_b),
        .d       (sspclkin),
        .q       (unused_sspclk_s),
        .fall    (fall_tick)
    );

    ssp_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .EDGE_EN (1'b0)
    ) u_sync_fss (
        .clk     (pclk),
        .clear_b (clear_b),
        .d       (sspfssin),
        .q       (fss_s),
        .fall    (unused_fss_fall)
    );

    ssp_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .EDGE_EN (1'b0)
    ) u_sync_rxd (
        .clk     (pclk),
        .clear_b (clear_b),
        .d       (ssprxd),
        .q       (rxd_s),
        .fall    (unused_rxd_fall)
    );

    // -----------------------------------------------------------------------
    // Frame FSM (stage boundary: synchronised inputs -> frame state)
    // -----------------------------------------------------------------------
    rx_state_t             state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [DATA_WIDTH-1:0] shift, shift_next;
    logic                  pend, pend_next;
    logic [DATA_WIDTH-1:0] rxdata_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shift_next = shift;
        pend_next  = pend;

        if (!rx_en) begin
            // Disable abandons any partial byte immediately.
            state_next = IDLE;
            cnt_next   = '0;
            pend_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_next = '0;
                    if (fall_tick && fss_s) begin
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    // The edge after frame sync carries the MSB; a repeated
                    // frame sync here is ignored.
                    if (fall_tick) begin
                        shift_next = {shift[DATA_WIDTH-2:0], rxd_s};
                        cnt_next   = CNT_W'(1);
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (fall_tick) begin
                        shift_next = {shift[DATA_WIDTH-2:0], rxd_s};
                        cnt_next   = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            state_next = DONE;
                            // Frame sync on the last bit starts the next
                            // frame without passing through IDLE.
                            pend_next  = fss_s;
                        end
                    end
                end
                DONE: begin
                    state_next = pend ? ARMED : IDLE;
                    pend_next  = 1'b0;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!clear_b) begin
            state      <= IDLE;
            cnt        <= '0;
            shift      <= '0;
            pend       <= 1'b0;
            rxdata_q   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            shift <= shift_next;
            pend  <= pend_next;
            if (w_en) begin
                rxdata_q <= shift;
            end
            if ((state == DONE) && rx_fifo_full) begin
                rx_overrun <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FIFO write interface (stage boundary: frame state -> FIFO)
    // -----------------------------------------------------------------------
    // The full flag is judged in the DONE cycle itself, the cycle the FIFO
    // would accept the write. rxdata presents the new byte from the same edge
    // that raises w_en and is captured into the hold register at the end of
    // DONE; a dropped byte never appears on rxdata.
    assign w_en    = (state == DONE) && !rx_fifo_full;
    assign rxdata  = w_en ? shift : rxdata_q;
    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_ssp_rx_deserializer.sv
module tb_ssp_rx_deserializer;

    logic       pclk = 1'b0;
    logic       clear_b;
    logic       rx_en;
    logic       sspclkin;
    logic       sspfssin;
    logic       ssprxd;
    logic       rx_fifo_full;
    logic [7:0] rxdata;
    logic       w_en;
    logic       rx_overrun;
    logic       rx_busy;

    int   tests = 0;
    int   fails = 0;

    // Reference model state: bytes the FIFO must receive, in order, and the
    // overrun flag the rules imply.
    logic [7:0] exp_q[$];
    bit         exp_ovr;
    int         wen_cnt = 0;
    bit         prev_wen = 1'b0;
    bit         watch_busy = 1'b0;
    bit         busy_gap = 1'b0;

    always #5 pclk = ~pclk;

    ssp_rx_deserializer #(
        .DATA_WIDTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .pclk         (pclk),
        .clear_b      (clear_b),
        .rx_en        (rx_en),
        .sspclkin     (sspclkin),
        .sspfssin     (sspfssin),
        .ssprxd       (ssprxd),
        .rx_fifo_full (rx_fifo_full),
        .rxdata       (rxdata),
        .w_en         (w_en),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // One serial bit: data/sync change with the rising sspclkin edge and are
    // stable across the falling edge, sspclkin = pclk/8.
    task automatic send_bit(input bit b, input bit f);
        ssprxd   = b;
        sspfssin = f;
        sspclkin = 1'b1;
        tick(4);
        sspclkin = 1'b0;
        tick(4);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit lead, input bit tail, input int spur);
        if (lead) send_bit(1'b0, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) watch_busy = 1'b0;
            send_bit(d[i], (i == 0 && tail) || (i == spur));
        end
        sspfssin = 1'b0;
    endtask

    // FIFO-side monitor: every write must match the next expected byte and
    // no two writes may be adjacent.
    initial begin
        forever begin
            @(negedge pclk);
            if (w_en === 1'b1) begin
                check("wen_single_cycle", prev_wen, 0);
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL wen_unexpected: wrote %0h, expected no write", rxdata);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    tests--;
                    check("wen_rxdata", rxdata, e);
                end
                wen_cnt++;
            end
            prev_wen = (w_en === 1'b1);
            if (watch_busy && rx_busy !== 1'b1) busy_gap = 1'b1;
        end
    end

    typedef struct {
        logic [7:0] data;
        bit         full;
        bit         b2b;
        int         spur;
        logic [7:0] exp_rx;
        int         exp_wens;
        bit         exp_ov;
    } vec_t;

    vec_t tbl[6];

    initial begin
        bit          chained;
        int          wen_base;
        logic [7:0]  d;
        bit          full;
        bit          b2b;
        int          spur;

        tbl[0] = '{8'hA5, 1'b0, 1'b0, -1, 8'hA5, 1, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 1'b1, -1, 8'h00, 0, 1'b0};
        tbl[2] = '{8'hC3, 1'b0, 1'b0, -1, 8'hC3, 2, 1'b0};
        tbl[3] = '{8'h5A, 1'b0, 1'b0,  5, 8'h5A, 1, 1'b0};
        tbl[4] = '{8'h7E, 1'b1, 1'b0, -1, 8'h5A, 0, 1'b1};
        tbl[5] = '{8'h11, 1'b0, 1'b0, -1, 8'h11, 1, 1'b1};

        clear_b      = 1'b0;
        rx_en        = 1'b1;
        sspclkin     = 1'b0;
        sspfssin     = 1'b0;
        ssprxd       = 1'b0;
        rx_fifo_full = 1'b0;
        exp_ovr      = 1'b0;
        tick(3);
        clear_b = 1'b1;
        tick(2);
        check("reset_rxdata", rxdata, 0);
        check("reset_wen", w_en, 0);
        check("reset_overrun", rx_overrun, 0);
        check("reset_busy", rx_busy, 0);

        // Directed table: single frame, back-to-back, spurious sync, overrun.
        chained  = 1'b0;
        wen_base = wen_cnt;
        for (int i = 0; i < 6; i++) begin
            rx_fifo_full = tbl[i].full;
            if (!tbl[i].full) exp_q.push_back(tbl[i].data);
            send_frame(tbl[i].data, !chained, tbl[i].b2b, tbl[i].spur);
            if (tbl[i].b2b) begin
                busy_gap   = 1'b0;
                watch_busy = 1'b1;
                chained    = 1'b1;
            end else begin
                tick(6);
                check($sformatf("tbl%0d_rxdata", i), rxdata, tbl[i].exp_rx);
                check($sformatf("tbl%0d_wen_count", i), wen_cnt - wen_base, tbl[i].exp_wens);
                check($sformatf("tbl%0d_overrun", i), rx_overrun, tbl[i].exp_ov);
                check($sformatf("tbl%0d_busy", i), rx_busy, 0);
                check($sformatf("tbl%0d_queue", i), exp_q.size(), 0);
                if (chained) check("b2b_no_idle", busy_gap, 0);
                chained  = 1'b0;
                wen_base = wen_cnt;
            end
        end
        rx_fifo_full = 1'b0;

        // Reset in the middle of a frame drops the partial byte and clears all.
        send_bit(1'b0, 1'b1);
        for (int i = 7; i >= 4; i--) send_bit(i[0] ? 1'b0 : 1'b1, 1'b0);
        clear_b = 1'b0;
        tick(1);
        clear_b = 1'b1;
        exp_ovr = 1'b0;
        check("midreset_rxdata", rxdata, 0);
        check("midreset_wen", w_en, 0);
        check("midreset_overrun", rx_overrun, 0);
        check("midreset_busy", rx_busy, 0);
        wen_base = wen_cnt;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        tick(6);
        check("after_reset_rxdata", rxdata, 8'h81);
        check("after_reset_wen_count", wen_cnt - wen_base, 1);

        // Enable drop after 5 bits of 0xFF.
        wen_base = wen_cnt;
        send_bit(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        rx_en = 1'b0;
        tick(2);
        check("rxen_drop_busy", rx_busy, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        tick(6);
        check("rxen_drop_wen_count", wen_cnt - wen_base, 0);
        check("rxen_drop_rxdata_held", rxdata, 8'h81);
        check("rxen_drop_busy_end", rx_busy, 0);
        rx_en = 1'b1;
        tick(2);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b0, -1);
        tick(6);
        check("rxen_resume_rxdata", rxdata, 8'h0F);
        check("rxen_resume_wen_count", wen_cnt - wen_base, 1);

        // Randomized frames against the model: random bytes, FIFO full,
        // continuous transfers and spurious frame syncs.
        chained = 1'b0;
        for (int k = 0; k < 30; k++) begin
            d    = 8'($urandom);
            full = ($urandom_range(0, 3) == 0);
            b2b  = (k != 29) && ($urandom_range(0, 2) == 0);
            spur = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : -1;
            rx_fifo_full = full;
            if (full) exp_ovr = 1'b1;
            else exp_q.push_back(d);
            send_frame(d, !chained, b2b, spur);
            chained = b2b;
            if (!b2b) tick(int'($urandom_range(1, 5)));
        end
        tick(6);
        rx_fifo_full = 1'b0;
        check("rand_overrun", rx_overrun, exp_ovr);
        check("rand_queue_drained", exp_q.size(), 0);
        check("rand_busy_idle", rx_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
